serial_subtractor: RTL and testbench

Bit-serial N-bit unsigned subtractor that computes A − B one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the sequential counterpart to the combinational full-adder cell in the arithmetic library. It sits behind a start/done handshake and serves area-constrained datapaths where latency of WIDTH cycles is acceptable.

---
 rtl/serial_subtractor_if.sv | 12 +
 rtl/serial_subtractor.sv | 79 +++++++
 tb/tb_serial_subtractor.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake bundle for the bit-serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial unsigned A-B using one full-subtractor cell and a registered borrow
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d, borrow_q, borrow_d;
  logic             x, y, d, bout;
  logic [WIDTH-1:0] d_sh;
  assign x    = a_q[0];
  assign y    = b_q[0];
  assign d    = x ^ y ^ bin_q;
  assign bout = (~x & y) | (~(x ^ y) & bin_q);
  assign d_sh = (d_q >> 1) | {d, {(WIDTH-1){1'b0}}};
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (state_q == SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      d_d   = d_sh;
      bin_d = bout;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        state_d  = DONE;
        diff_d   = d_sh;
        borrow_d = bout;
      end
    end else if (bus.start) begin
      state_d = SHIFT;
      a_d     = bus.a;
      b_d     = bus.b;
      d_d     = '0;
      bin_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end
  assign bus.busy   = state_q == SHIFT;
  assign bus.done   = state_q == DONE;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboarded random and directed checks of two subtractor widths
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   done8_cnt = 0;
  logic [8:0]  q8[$];
  logic [13:0] q13[$];
  always #5 clk = ~clk;
  serial_subtractor_if #(.WIDTH(8))  i8 ();
  serial_subtractor_if #(.WIDTH(13)) i13 ();
  serial_subtractor #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  serial_subtractor #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(i13.slave));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && i8.done) begin
      logic [8:0] e;
      done8_cnt++;
      chk("busy_at_done8", {31'b0, i8.busy}, 0);
      chk("done_expected8", {31'b0, q8.size() != 0}, 1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("diff8", {24'b0, i8.diff}, {24'b0, e[7:0]});
        chk("borrow8", {31'b0, i8.borrow}, {31'b0, e[8]});
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n && i13.done) begin
      logic [13:0] e;
      chk("busy_at_done13", {31'b0, i13.busy}, 0);
      chk("done_expected13", {31'b0, q13.size() != 0}, 1);
      if (q13.size() != 0) begin
        e = q13.pop_front();
        chk("diff13", {19'b0, i13.diff}, {19'b0, e[12:0]});
        chk("borrow13", {31'b0, i13.borrow}, {31'b0, e[13]});
      end
    end
  end
  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a - b;
    return {a < b, d};
  endfunction
  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (i8.busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("issue8_timeout", t, 0);
    i8.start = 1'b1;
    i8.a = a;
    i8.b = b;
    q8.push_back(ref8(a, b));
    @(negedge clk);
    i8.start = 1'b0;
  endtask
  task automatic wait_idle8();
    int t = 0;
    while ((q8.size() != 0 || i8.busy || i8.done) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("idle8_timeout", t, 0);
  endtask
  task automatic issue13(input logic [12:0] a, input logic [12:0] b);
    int t = 0;
    logic [12:0] d;
    @(negedge clk);
    while (i13.busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("issue13_timeout", t, 0);
    d = a - b;
    i13.start = 1'b1;
    i13.a = a;
    i13.b = b;
    q13.push_back({a < b, d});
    @(negedge clk);
    i13.start = 1'b0;
  endtask
  initial begin
    logic [7:0] va[5];
    logic [7:0] vb[5];
    int t, base;
    va = '{8'h13, 8'h00, 8'hFF, 8'hFF, 8'h5A};
    vb = '{8'h5A, 8'h01, 8'hFF, 8'h00, 8'h13};
    i8.start = 0; i8.a = 0; i8.b = 0;
    i13.start = 0; i13.a = 0; i13.b = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, i8.busy}, 0);
    chk("rst_done", {31'b0, i8.done}, 0);
    chk("rst_diff", {24'b0, i8.diff}, 0);
    chk("rst_borrow", {31'b0, i8.borrow}, 0);
    rst_n = 1'b1;
    // Latency: accepted at edge k, busy for 8 cycles, done after edge k+8
    @(negedge clk);
    i8.start = 1; i8.a = 8'h5A; i8.b = 8'h13;
    q8.push_back(ref8(8'h5A, 8'h13));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      i8.start = 0;
      chk("lat_busy", {31'b0, i8.busy}, 1);
      chk("lat_nodone", {31'b0, i8.done}, 0);
    end
    @(negedge clk);
    chk("lat_done", {31'b0, i8.done}, 1);
    @(negedge clk);
    chk("done_drop", {31'b0, i8.done}, 0);
    chk("hold_diff", {24'b0, i8.diff}, 32'h47);
    chk("hold_borrow", {31'b0, i8.borrow}, 0);
    for (int i = 0; i < 5; i++) issue8(va[i], vb[i]);
    wait_idle8();
    // Start mid-SHIFT with operands churning must be ignored
    base = done8_cnt;
    issue8(8'h5A, 8'h13);
    repeat (2) @(negedge clk);
    i8.start = 1; i8.a = 8'h00; i8.b = 8'hFF;
    @(negedge clk);
    i8.start = 0;
    for (int i = 0; i < 8; i++) begin
      i8.a = 8'($urandom);
      i8.b = 8'($urandom);
      @(negedge clk);
    end
    wait_idle8();
    repeat (3) @(negedge clk);
    chk("one_done", done8_cnt - base, 1);
    // Back-to-back with start held high
    i8.start = 1; i8.a = 8'h10; i8.b = 8'h01;
    q8.push_back(ref8(8'h10, 8'h01));
    t = 0;
    do begin @(negedge clk); t++; end while (!i8.done && t < 30);
    i8.a = 8'h01; i8.b = 8'h10;
    q8.push_back(ref8(8'h01, 8'h10));
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (t == 4) chk("b2b_hold", {24'b0, i8.diff}, 32'h0F);
    end while (!i8.done && t < 30);
    i8.start = 0;
    chk("b2b_period", t, 9);
    wait_idle8();
    // Reset in the 4th SHIFT cycle discards the result
    issue8(8'h5A, 8'h13);
    repeat (3) @(negedge clk);
    rst_n = 0;
    q8.delete();
    @(negedge clk);
    rst_n = 1;
    chk("mid_rst_busy", {31'b0, i8.busy}, 0);
    chk("mid_rst_done", {31'b0, i8.done}, 0);
    chk("mid_rst_diff", {24'b0, i8.diff}, 0);
    chk("mid_rst_borrow", {31'b0, i8.borrow}, 0);
    base = done8_cnt;
    repeat (12) @(negedge clk);
    chk("no_done_after_rst", done8_cnt - base, 0);
    issue8(8'h80, 8'h7F);
    wait_idle8();
    fork
      for (int i = 0; i < 1000; i++) begin
        issue8(8'($urandom), 8'($urandom));
        if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
      end
      for (int i = 0; i < 1000; i++) begin
        issue13(13'($urandom), 13'($urandom));
        if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 15)) @(negedge clk);
      end
    join
    t = 0;
    while ((q8.size() != 0 || q13.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("q8_drained", q8.size(), 0);
    chk("q13_drained", q13.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
